// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - pipeline freeze/flush sequencer with iterative-divider handshake
module pipeline_stall_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_stall,
    input  logic             redirect,
    input  logic             md_req,
    input  logic             md_done,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_we,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic             md_start,
    output logic             md_result_sel,
    output logic             md_error,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WAIT_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MD_TIMEOUT - 1);

    typedef enum logic {RUN, MD_BUSY} state_t;

    state_t            state, nextState;
    logic [WAIT_W-1:0] waitCnt;
    logic              mdMask;

    logic pcWe, ifIdWe, idExWe, ifIdFlush, idExBubble, exMemBubble, resultSel;
    logic acceptMd, leaveBusy, mdTimeout;

    always_comb begin
        nextState   = state;
        pcWe        = 1'b1;
        ifIdWe      = 1'b1;
        idExWe      = 1'b1;
        ifIdFlush   = 1'b0;
        idExBubble  = 1'b0;
        exMemBubble = 1'b0;
        resultSel   = 1'b0;
        acceptMd    = 1'b0;
        leaveBusy   = 1'b0;
        mdTimeout   = 1'b0;
        case (state)
            RUN: begin
                if (redirect) begin
                    ifIdFlush  = 1'b1;
                    idExBubble = 1'b1;
                end else if (md_req && !mdMask) begin
                    pcWe        = 1'b0;
                    ifIdWe      = 1'b0;
                    idExWe      = 1'b0;
                    exMemBubble = 1'b1;
                    acceptMd    = 1'b1;
                    nextState   = MD_BUSY;
                end else if (load_use_stall) begin
                    pcWe       = 1'b0;
                    ifIdWe     = 1'b0;
                    idExBubble = 1'b1;
                end
            end
            MD_BUSY: begin
                if (md_done) begin
                    resultSel = 1'b1;
                    leaveBusy = 1'b1;
                    nextState = RUN;
                end else if (waitCnt == WAIT_LAST) begin
                    // Divider never answered: let the pipeline move on with the instruction dropped.
                    exMemBubble = 1'b1;
                    mdTimeout   = 1'b1;
                    leaveBusy   = 1'b1;
                    nextState   = RUN;
                end else begin
                    pcWe        = 1'b0;
                    ifIdWe      = 1'b0;
                    idExWe      = 1'b0;
                    exMemBubble = 1'b1;
                end
            end
            default: nextState = RUN;
        endcase
    end

    assign pc_we         = rst_n & pcWe;
    assign if_id_we      = rst_n & ifIdWe;
    assign id_ex_we      = rst_n & idExWe;
    assign if_id_flush   = ~rst_n | ifIdFlush;
    assign id_ex_bubble  = ~rst_n | idExBubble;
    assign ex_mem_bubble = ~rst_n | exMemBubble;
    assign md_result_sel = rst_n & resultSel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            waitCnt      <= '0;
            mdMask       <= 1'b0;
            md_start     <= 1'b0;
            md_error     <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state    <= nextState;
            md_start <= acceptMd;
            // The instruction in EX is still the finished DIV until the next edge.
            mdMask   <= leaveBusy;
            if (acceptMd || leaveBusy) begin
                waitCnt <= '0;
            end else if (state == MD_BUSY) begin
                waitCnt <= waitCnt + WAIT_W'(1);
            end
            if (mdTimeout) begin
                md_error <= 1'b1;
            end
            if (!pcWe && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - directed self-checking bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_use_stall = 1'b0;
    logic redirect = 1'b0;
    logic md_req = 1'b0;
    logic md_done = 1'b0;

    logic        pcWeA, ifIdWeA, ifIdFlushA, idExWeA, idExBubA, exMemBubA, mdStartA, selA, errA;
    logic [31:0] stallA;
    logic        pcWeB, ifIdWeB, ifIdFlushB, idExWeB, idExBubB, exMemBubB, mdStartB, selB, errB;
    logic [2:0]  stallB;

    int nTests = 0;
    int nFail  = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.MD_TIMEOUT(64), .CNT_W(32)) dutA (
        .clk(clk), .rst_n(rst_n), .load_use_stall(load_use_stall), .redirect(redirect),
        .md_req(md_req), .md_done(md_done), .pc_we(pcWeA), .if_id_we(ifIdWeA),
        .if_id_flush(ifIdFlushA), .id_ex_we(idExWeA), .id_ex_bubble(idExBubA),
        .ex_mem_bubble(exMemBubA), .md_start(mdStartA), .md_result_sel(selA),
        .md_error(errA), .stall_cycles(stallA)
    );

    pipeline_stall_ctrl #(.MD_TIMEOUT(4), .CNT_W(3)) dutB (
        .clk(clk), .rst_n(rst_n), .load_use_stall(load_use_stall), .redirect(redirect),
        .md_req(md_req), .md_done(md_done), .pc_we(pcWeB), .if_id_we(ifIdWeB),
        .if_id_flush(ifIdFlushB), .id_ex_we(idExWeB), .id_ex_bubble(idExBubB),
        .ex_mem_bubble(exMemBubB), .md_start(mdStartB), .md_result_sel(selB),
        .md_error(errB), .stall_cycles(stallB)
    );

    // {pc_we, if_id_we, id_ex_we, if_id_flush, id_ex_bubble, ex_mem_bubble, md_start, md_result_sel}
    logic [7:0] vecA, vecB;
    assign vecA = {pcWeA, ifIdWeA, idExWeA, ifIdFlushA, idExBubA, exMemBubA, mdStartA, selA};
    assign vecB = {pcWeB, ifIdWeB, idExWeB, ifIdFlushB, idExBubB, exMemBubB, mdStartB, selB};

    task automatic step(input logic lu, input logic rd, input logic mr, input logic md);
        @(negedge clk);
        load_use_stall = lu;
        redirect       = rd;
        md_req         = mr;
        md_done        = md;
        #1;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_n = 1'b0;
        load_use_stall = 1'b0; redirect = 1'b0; md_req = 1'b0; md_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        nTests++;
        if (vecA !== 8'b000_111_00) begin
            nFail++; $display("FAIL reset_outputs: got %b expected %b", vecA, 8'b000_111_00);
        end
        nTests++;
        if (stallA !== 32'd0 || errA !== 1'b0) begin
            nFail++; $display("FAIL reset_regs: got stall=%0d err=%b expected 0 0", stallA, errA);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        nTests++;
        if (vecA !== 8'b111_000_00) begin
            nFail++; $display("FAIL reset_release_idle: got %b expected %b", vecA, 8'b111_000_00);
        end
    endtask

    task automatic test_load_use();
        applyReset();
        step(1, 0, 0, 0);
        nTests++;
        if (vecA !== 8'b001_010_00) begin
            nFail++; $display("FAIL load_use_outputs: got %b expected %b", vecA, 8'b001_010_00);
        end
        step(0, 0, 0, 0);
        nTests++;
        if (stallA !== 32'd1 || vecA !== 8'b111_000_00) begin
            nFail++; $display("FAIL load_use_after: got stall=%0d vec=%b expected 1 11100000", stallA, vecA);
        end
    endtask

    task automatic test_redirect();
        step(1, 1, 1, 0);
        nTests++;
        if (vecA !== 8'b111_110_00) begin
            nFail++; $display("FAIL redirect_priority: got %b expected %b", vecA, 8'b111_110_00);
        end
        step(0, 0, 0, 0);
        nTests++;
        if (stallA !== 32'd1 || mdStartA !== 1'b0) begin
            nFail++; $display("FAIL redirect_after: got stall=%0d start=%b expected 1 0", stallA, mdStartA);
        end
    endtask

    task automatic test_md_done();
        applyReset();
        step(0, 0, 1, 0);
        nTests++;
        if (vecA !== 8'b000_001_00) begin
            nFail++; $display("FAIL md_accept: got %b expected %b", vecA, 8'b000_001_00);
        end
        step(0, 0, 0, 0);
        nTests++;
        if (vecA !== 8'b000_001_10) begin
            nFail++; $display("FAIL md_start_pulse: got %b expected %b", vecA, 8'b000_001_10);
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 1, 1, 0);
            nTests++;
            if (vecA !== 8'b000_001_00) begin
                nFail++; $display("FAIL md_busy_%0d: got %b expected %b", i, vecA, 8'b000_001_00);
            end
        end
        step(0, 0, 0, 1);
        nTests++;
        if (vecA !== 8'b111_000_01) begin
            nFail++; $display("FAIL md_done_advance: got %b expected %b", vecA, 8'b111_000_01);
        end
        // Next cycle: md_req still high from the old DIV must be masked.
        step(0, 0, 1, 0);
        nTests++;
        if (vecA !== 8'b111_000_00 || stallA !== 32'd6) begin
            nFail++; $display("FAIL md_mask: got vec=%b stall=%0d expected 11100000 6", vecA, stallA);
        end
        step(0, 0, 1, 0);
        nTests++;
        if (vecA !== 8'b000_001_00) begin
            nFail++; $display("FAIL md_reaccept: got %b expected %b", vecA, 8'b000_001_00);
        end
        step(0, 0, 0, 1);
        nTests++;
        if (vecA !== 8'b111_000_11) begin
            nFail++; $display("FAIL md_done_first_cycle: got %b expected %b", vecA, 8'b111_000_11);
        end
        step(0, 0, 0, 1);
        nTests++;
        if (vecA !== 8'b111_000_00 || stallA !== 32'd7 || errA !== 1'b0) begin
            nFail++; $display("FAIL md_spurious_done: got vec=%b stall=%0d err=%b expected 11100000 7 0", vecA, stallA, errA);
        end
    endtask

    task automatic test_timeout();
        applyReset();
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        nTests++;
        if (vecB !== 8'b000_001_10) begin
            nFail++; $display("FAIL to_start: got %b expected %b", vecB, 8'b000_001_10);
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0);
            nTests++;
            if (vecB !== 8'b000_001_00) begin
                nFail++; $display("FAIL to_busy_%0d: got %b expected %b", i, vecB, 8'b000_001_00);
            end
        end
        step(0, 0, 0, 0);
        nTests++;
        if (vecB !== 8'b111_001_00 || errB !== 1'b0) begin
            nFail++; $display("FAIL to_abort: got vec=%b err=%b expected 11100100 0", vecB, errB);
        end
        step(0, 0, 0, 0);
        nTests++;
        if (vecB !== 8'b111_000_00 || errB !== 1'b1) begin
            nFail++; $display("FAIL to_error_set: got vec=%b err=%b expected 11100000 1", vecB, errB);
        end
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        nTests++;
        if (errB !== 1'b1) begin
            nFail++; $display("FAIL to_error_sticky: got %b expected 1", errB);
        end
    endtask

    task automatic test_reset_mid_busy();
        applyReset();
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        nTests++;
        if (vecA !== 8'b000_111_00 || stallA !== 32'd0) begin
            nFail++; $display("FAIL rst_mid_busy: got vec=%b stall=%0d expected 00011100 0", vecA, stallA);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            nTests++;
            if (vecA !== 8'b111_000_00) begin
                nFail++; $display("FAIL rst_release_%0d: got %b expected %b", i, vecA, 8'b111_000_00);
            end
        end
    endtask

    task automatic test_saturate();
        applyReset();
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0, 0);
            if (i == 5) begin
                nTests++;
                if (stallB !== 3'd5) begin
                    nFail++; $display("FAIL sat_mid: got %0d expected 5", stallB);
                end
            end
        end
        step(0, 0, 0, 0);
        nTests++;
        if (stallB !== 3'd7) begin
            nFail++; $display("FAIL sat_hold: got %0d expected 7", stallB);
        end
        nTests++;
        if (stallA !== 32'd10) begin
            nFail++; $display("FAIL sat_wide_count: got %0d expected 10", stallA);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_redirect();
        test_md_done();
        test_timeout();
        test_reset_mid_busy();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
